// File: rtl/move_scheduler.sv
// move_scheduler: merges key presses, auto-repeat and gravity
// into one move request at a time over a valid/ack handshake.
module move_scheduler #(
    parameter int CNT_W      = 26,
    parameter int GRAV_INIT  = 25_000_000,
    parameter int GRAV_MIN   = 2_500_000,
    parameter int GRAV_STEP  = 2_500_000,
    parameter int DAS_DELAY  = 6_000_000,
    parameter int ARR_PERIOD = 2_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             right,
    input  logic             left,
    input  logic             rr,
    input  logic             rl,
    input  logic             down,
    input  logic             move_ack,
    input  logic             lock_i,
    input  logic             level_up,
    output logic [2:0]       move_o,
    output logic             move_valid,
    output logic [CNT_W-1:0] grav_period_o
);

    localparam logic [2:0] MV_RIGHT = 3'd0;
    localparam logic [2:0] MV_LEFT  = 3'd1;
    localparam logic [2:0] MV_ROR   = 3'd2;
    localparam logic [2:0] MV_ROL   = 3'd3;
    localparam logic [2:0] MV_DOWN  = 3'd4;
    localparam logic [2:0] MV_NONE  = 3'd5;

    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_GINIT = CNT_W'(GRAV_INIT);
    localparam logic [CNT_W-1:0] C_GMIN  = CNT_W'(GRAV_MIN);
    localparam logic [CNT_W-1:0] C_GSTEP = CNT_W'(GRAV_STEP);
    localparam logic [CNT_W-1:0] C_GTHR  = CNT_W'(GRAV_MIN + GRAV_STEP);
    localparam logic [CNT_W-1:0] C_DAS   = CNT_W'(DAS_DELAY);
    localparam logic [CNT_W-1:0] C_ARR   = CNT_W'(ARR_PERIOD);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    // Pending bits are indexed by move code: RIGHT, LEFT, ROR, ROL, DOWN.
    logic [4:0] r_prev;
    logic [4:0] r_pend;
    logic [4:0] w_pend_nx;
    logic [4:0] w_keys;
    logic [4:0] w_rise;
    logic [4:0] w_clr;
    logic [4:0] w_rep_bits;

    logic [2:0] r_move;
    logic [2:0] w_sel;
    logic       w_grant;
    logic       w_ack_ok;
    logic       w_grav_hit;

    // Repeating keys, slot order: right, left, down.
    logic [2:0]            w_rkey;
    logic [2:0]            w_rrise;
    logic [2:0]            w_rset;
    logic [2:0]            r_rep;
    logic [2:0]            w_rep_nx;
    logic [2:0][CNT_W-1:0] r_hold;
    logic [2:0][CNT_W-1:0] w_hold_nx;

    logic [CNT_W-1:0] r_gcnt;
    logic [CNT_W-1:0] r_grav_period;

    assign w_keys     = {down, rl, rr, left, right};
    assign w_rise     = w_keys & ~r_prev & {5{en}};
    assign w_rkey     = {down, left, right};
    assign w_rrise    = {w_rise[4], w_rise[1], w_rise[0]};
    assign w_rep_bits = {w_rset[2], 2'b00, w_rset[1], w_rset[0]};

    assign w_grav_hit = en & ~lock_i
                      & (r_gcnt >= r_grav_period - C_ONE);

    assign w_grant  = (r_state == S_IDLE) & en & (|r_pend);
    assign w_ack_ok = (r_state == S_ISSUE) & move_ack;
    assign w_clr    = w_ack_ok ? (5'b00001 << r_move) : 5'b00000;

    assign grav_period_o = r_grav_period;

    // Previous key levels; tracked even while disabled so a key held
    // across enable does not look like a fresh press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_keys;
        end
    end

    // Hold counters: DAS delay first, then ARR period while held.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_hold_nx[k] = r_hold[k];
            w_rep_nx[k]  = r_rep[k];
            w_rset[k]    = 1'b0;
            if (!en || !w_rkey[k]) begin
                w_hold_nx[k] = '0;
                w_rep_nx[k]  = 1'b0;
            end else if (w_rrise[k]) begin
                w_hold_nx[k] = C_ONE;
                w_rep_nx[k]  = 1'b0;
            end else if (r_hold[k] != '0) begin
                if (!r_rep[k] && r_hold[k] == C_DAS) begin
                    w_rset[k]    = 1'b1;
                    w_hold_nx[k] = C_ONE;
                    w_rep_nx[k]  = 1'b1;
                end else if (r_rep[k] && r_hold[k] == C_ARR) begin
                    w_rset[k]    = 1'b1;
                    w_hold_nx[k] = C_ONE;
                end else begin
                    w_hold_nx[k] = r_hold[k] + C_ONE;
                end
            end
        end
    end

    // Hold counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold <= '0;
            r_rep  <= '0;
        end else begin
            r_hold <= w_hold_nx;
            r_rep  <= w_rep_nx;
        end
    end

    // Gravity counter; lock and disable both restart it from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gcnt <= '0;
        end else if (!en || lock_i || w_grav_hit) begin
            r_gcnt <= '0;
        end else begin
            r_gcnt <= r_gcnt + C_ONE;
        end
    end

    // Gravity period shortens per level-up, clamped at the floor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grav_period <= C_GINIT;
        end else if (level_up) begin
            if (r_grav_period >= C_GTHR) begin
                r_grav_period <= r_grav_period - C_GSTEP;
            end else begin
                r_grav_period <= C_GMIN;
            end
        end
    end

    // Pending update: clears first, so a set in the same cycle wins.
    always_comb begin
        w_pend_nx = r_pend & ~w_clr;
        if (lock_i) begin
            w_pend_nx[4] = 1'b0;
        end
        w_pend_nx = w_pend_nx | w_rise | w_rep_bits
                  | {w_grav_hit, 4'b0000};
        if (!en) begin
            w_pend_nx = '0;
        end
    end

    // Pending register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nx;
        end
    end

    // Fixed priority pick: DOWN > ROR > ROL > RIGHT > LEFT.
    always_comb begin
        w_sel = MV_NONE;
        if (r_pend[4]) begin
            w_sel = MV_DOWN;
        end else if (r_pend[2]) begin
            w_sel = MV_ROR;
        end else if (r_pend[3]) begin
            w_sel = MV_ROL;
        end else if (r_pend[0]) begin
            w_sel = MV_RIGHT;
        end else if (r_pend[1]) begin
            w_sel = MV_LEFT;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next state; an outstanding grant finishes even when disabled.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (move_ack) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Granted move code, latched at grant and dropped at ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_move <= MV_NONE;
        end else if (w_grant) begin
            r_move <= w_sel;
        end else if (w_ack_ok) begin
            r_move <= MV_NONE;
        end
    end

    // FSM outputs; decoded from state so reset clears them at once.
    always_comb begin
        move_valid = 1'b0;
        move_o     = MV_NONE;
        case (r_state)
            S_ISSUE: begin
                move_valid = 1'b1;
                move_o     = r_move;
            end
            default: begin
                move_valid = 1'b0;
                move_o     = MV_NONE;
            end
        endcase
    end

endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: vector table and sequences for move_scheduler,
// grants checked against an expected-grant queue.
module tb_move_scheduler;

    localparam int CW = 26;

    localparam logic [2:0] M_R    = 3'd0;
    localparam logic [2:0] M_L    = 3'd1;
    localparam logic [2:0] M_ROR  = 3'd2;
    localparam logic [2:0] M_ROL  = 3'd3;
    localparam logic [2:0] M_DN   = 3'd4;
    localparam logic [2:0] M_NONE = 3'd5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          right = 1'b0;
    logic          left = 1'b0;
    logic          rr = 1'b0;
    logic          rl = 1'b0;
    logic          down = 1'b0;
    logic          move_ack = 1'b0;
    logic          lock_i = 1'b0;
    logic          level_up = 1'b0;
    logic [2:0]    move_o;
    logic          move_valid;
    logic [CW-1:0] grav_period_o;

    // keys: {rl, rr, left, right}; code/off element 0 is the first grant
    typedef struct packed {
        logic [3:0]      keys;
        logic [7:0]      hold;
        logic [7:0]      ack;
        logic [2:0]      n;
        logic [4:0][2:0] code;
        logic [4:0][7:0] off;
    } vec_t;

    typedef struct {
        logic [2:0] code;
        int         cyc;
    } exp_t;

    exp_t exq[$];
    vec_t vt[11];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   ack_dly = 0;

    move_scheduler #(
        .CNT_W(CW),
        .GRAV_INIT(8),
        .GRAV_MIN(2),
        .GRAV_STEP(3),
        .DAS_DELAY(4),
        .ARR_PERIOD(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .right(right),
        .left(left),
        .rr(rr),
        .rl(rl),
        .down(down),
        .move_ack(move_ack),
        .lock_i(lock_i),
        .level_up(level_up),
        .move_o(move_o),
        .move_valid(move_valid),
        .grav_period_o(grav_period_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic [3:0] k, input int h,
                                input int a, input int n,
                                input logic [14:0] c,
                                input logic [39:0] o);
        vec_t v;
        v.keys = k;
        v.hold = 8'(h);
        v.ack  = 8'(a);
        v.n    = 3'(n);
        v.code = c;
        v.off  = o;
        return v;
    endfunction

    task automatic push(input logic [2:0] c, input int at);
        exp_t e;
        e.code = c;
        e.cyc  = at;
        exq.push_back(e);
    endtask

    task automatic check_val(input string nm, input int got,
                             input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    task automatic check_drained(input string nm);
        checks++;
        if (exq.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d grants missing, required 0",
                     nm, exq.size());
        end
        exq.delete();
    endtask

    // Acks each grant after ack_dly extra cycles; checks order,
    // grant cycle and that move_o stays stable while waiting.
    task automatic monitor();
        bit         seen = 1'b0;
        int         w = 0;
        logic [2:0] cur = M_NONE;
        exp_t       e;
        forever begin
            @(negedge clk);
            move_ack = 1'b0;
            if (!rst) begin
                seen = 1'b0;
                w    = 0;
            end else if (move_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    w    = 0;
                    cur  = move_o;
                    checks++;
                    if (exq.size() == 0) begin
                        errors++;
                        $display("FAIL grant_extra: got move %0d at cycle %0d, required none",
                                 move_o, cyc);
                    end else begin
                        e = exq.pop_front();
                        if (move_o !== e.code || cyc != e.cyc) begin
                            errors++;
                            $display("FAIL grant: got move %0d at cycle %0d, required move %0d at cycle %0d",
                                     move_o, cyc, e.code, e.cyc);
                        end
                    end
                end else begin
                    checks++;
                    if (move_o !== cur) begin
                        errors++;
                        $display("FAIL hold_stable: got move %0d, required %0d",
                                 move_o, cur);
                    end
                end
                if (w >= ack_dly) begin
                    move_ack = 1'b1;
                    seen     = 1'b0;
                end else begin
                    w++;
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        fork
            monitor();
        join_none

        vt[0]  = mk(4'b0001, 1, 0, 1, {M_R, M_R, M_R, M_R, M_R},
                    {8'd0, 8'd0, 8'd0, 8'd0, 8'd1});
        vt[1]  = mk(4'b0010, 1, 0, 1, {M_R, M_R, M_R, M_R, M_L},
                    {8'd0, 8'd0, 8'd0, 8'd0, 8'd1});
        vt[2]  = mk(4'b0100, 1, 0, 1, {M_R, M_R, M_R, M_R, M_ROR},
                    {8'd0, 8'd0, 8'd0, 8'd0, 8'd1});
        vt[3]  = mk(4'b1000, 1, 0, 1, {M_R, M_R, M_R, M_R, M_ROL},
                    {8'd0, 8'd0, 8'd0, 8'd0, 8'd1});
        vt[4]  = mk(4'b0011, 1, 0, 2, {M_R, M_R, M_R, M_L, M_R},
                    {8'd0, 8'd0, 8'd0, 8'd3, 8'd1});
        vt[5]  = mk(4'b1110, 1, 0, 3, {M_R, M_R, M_L, M_ROL, M_ROR},
                    {8'd0, 8'd0, 8'd5, 8'd3, 8'd1});
        vt[6]  = mk(4'b1111, 1, 0, 4, {M_R, M_L, M_R, M_ROL, M_ROR},
                    {8'd0, 8'd7, 8'd5, 8'd3, 8'd1});
        vt[7]  = mk(4'b0001, 12, 0, 5, {M_R, M_R, M_R, M_R, M_R},
                    {8'd11, 8'd9, 8'd7, 8'd5, 8'd1});
        vt[8]  = mk(4'b0100, 12, 0, 1, {M_R, M_R, M_R, M_R, M_ROR},
                    {8'd0, 8'd0, 8'd0, 8'd0, 8'd1});
        vt[9]  = mk(4'b0101, 1, 2, 2, {M_R, M_R, M_R, M_R, M_ROR},
                    {8'd0, 8'd0, 8'd0, 8'd5, 8'd1});
        vt[10] = mk(4'b0010, 5, 0, 2, {M_R, M_R, M_R, M_L, M_L},
                    {8'd0, 8'd0, 8'd0, 8'd5, 8'd1});

        // reset state
        repeat (3) @(negedge clk);
        check_val("rst_valid", int'(move_valid), 0);
        check_val("rst_move", int'(move_o), int'(M_NONE));
        check_val("rst_period", int'(grav_period_o), 8);
        rst = 1'b1;
        en = 1'b1;
        lock_i = 1'b1;
        repeat (2) @(negedge clk);

        // key vectors; lock held so gravity stays quiet
        for (int i = 0; i < 11; i++) begin
            ack_dly = int'(vt[i].ack);
            p = cyc + 1;
            {rl, rr, left, right} = vt[i].keys;
            for (int j = 0; j < int'(vt[i].n); j++)
                push(vt[i].code[j], p + int'(vt[i].off[j]));
            repeat (int'(vt[i].hold)) @(negedge clk);
            {rl, rr, left, right} = 4'b0000;
            repeat (16) @(negedge clk);
            check_drained($sformatf("vec%0d", i));
        end
        ack_dly = 0;

        // key held across enable is not a press
        en = 1'b0;
        right = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (12) @(negedge clk);
        right = 1'b0;
        repeat (3) @(negedge clk);
        check_drained("held_over_en");
        p = cyc + 1;
        right = 1'b1;
        push(M_R, p + 1);
        @(negedge clk);
        right = 1'b0;
        repeat (6) @(negedge clk);
        check_drained("repress");

        // gravity every 8 cycles
        en = 1'b0;
        lock_i = 1'b0;
        @(negedge clk);
        en = 1'b1;
        p = cyc + 1;
        push(M_DN, p + 8);
        push(M_DN, p + 16);
        push(M_DN, p + 24);
        check_val("period8", int'(grav_period_o), 8);
        repeat (27) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        check_drained("gravity8");

        // lock in the expiry cycle
        en = 1'b1;
        p = cyc + 1;
        repeat (7) @(negedge clk);
        lock_i = 1'b1;
        @(negedge clk);
        lock_i = 1'b0;
        push(M_DN, p + 16);
        repeat (11) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        check_drained("lock_beats_grav");

        // level-up: 8 -> 5, spacing 5
        level_up = 1'b1;
        @(negedge clk);
        level_up = 1'b0;
        check_val("lvl_1", int'(grav_period_o), 5);
        en = 1'b1;
        p = cyc + 1;
        push(M_DN, p + 5);
        push(M_DN, p + 10);
        repeat (12) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        check_drained("spacing5");

        // level-up: 5 -> 2 -> 2 -> 2, spacing 2
        for (int k = 0; k < 3; k++) begin
            level_up = 1'b1;
            @(negedge clk);
            level_up = 1'b0;
            check_val($sformatf("lvl_%0d", k + 2),
                      int'(grav_period_o), 2);
        end
        en = 1'b1;
        p = cyc + 1;
        push(M_DN, p + 2);
        push(M_DN, p + 4);
        push(M_DN, p + 6);
        repeat (7) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        check_drained("spacing2");

        // async reset while a grant is outstanding
        en = 1'b1;
        lock_i = 1'b1;
        ack_dly = 6;
        p = cyc + 1;
        rr = 1'b1;
        push(M_ROR, p + 1);
        @(negedge clk);
        rr = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_val("rst_mid_valid", int'(move_valid), 0);
        check_val("rst_mid_move", int'(move_o), int'(M_NONE));
        check_val("rst_mid_period", int'(grav_period_o), 8);
        @(negedge clk);
        rst = 1'b1;
        ack_dly = 0;
        repeat (12) @(negedge clk);
        check_val("post_rst_valid", int'(move_valid), 0);
        check_drained("no_stale");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
